mem_read_arbiter: RTL and testbench

- Parametrised N-channel read arbiter between the strip drivers and the single-read-port frame bram.
- Replaces the fixed 8-channel arbiter; channel count, address/data width, memory read latency and arbitration mode are all parameters.
- Issues at most one memory read per cycle, fully pipelined, with per-channel return data and ready pulses.

---
 rtl/ledsuit_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mem_read_arbiter.sv | 111 +++++++++++
 tb/tb_mem_read_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledsuit_pkg.sv
// Shared definitions for the LED suit frame path.
// CH_IDX_W(n) : width of a channel index for n channels, never below 1 bit.
// LED_DATA_W   : default frame bram data width.
// DEFAULT_ADDR_W : default frame bram address width.
package ledsuit_pkg;

  localparam int LED_DATA_W     = 8;
  localparam int DEFAULT_ADDR_W = 9;

  function automatic int CH_IDX_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational single-grant arbiter.
// Ports:
//   eligible    - per-channel eligibility mask
//   pointer     - last granted index; search starts just after it
//   grant_valid - at least one channel is eligible
//   grant_idx   - index of the winning channel
// With ROUND_ROBIN=0 the search start is pinned to NUM_CHANNELS-1, which
// turns the same rotate into a fixed lowest-index-wins priority.
module rr_arbiter import ledsuit_pkg::*; #(
  parameter int NUM_CHANNELS = 8,
  parameter int ROUND_ROBIN  = 1,
  parameter int IDX_W        = CH_IDX_W(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eligible,
  input  logic [IDX_W-1:0]        pointer,
  output logic                    grant_valid,
  output logic [IDX_W-1:0]        grant_idx
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] cand;

  assign start = (ROUND_ROBIN != 0) ? pointer : IDX_W'(NUM_CHANNELS - 1);

  // Walk from the farthest candidate to the nearest so the channel closest
  // after 'start' is the last (and therefore winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_CHANNELS; k >= 1; k--) begin
      cand = IDX_W'((int'(start) + k) % NUM_CHANNELS);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// N-channel read arbiter in front of a single-read-port frame bram.
// One read issued per cycle at most; each return is steered to the
// requesting channel's data slice with a one-cycle data_rdy pulse.
// Ports:
//   clk, rst       - system clock, synchronous active-high reset
//   data_req       - per-channel read request (level)
//   data_addr      - channel i address at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   data           - channel i return data at [i*DATA_WIDTH +: DATA_WIDTH]
//   data_rdy       - one-cycle pulse, channel slice of data is valid
//   mem_data_addr  - registered bram read address
//   mem_ren        - registered bram read enable
//   mem_data       - bram read data, READ_LATENCY edges after the address
module mem_read_arbiter import ledsuit_pkg::*; #(
  parameter int NUM_CHANNELS  = 8,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDR_W,
  parameter int DATA_WIDTH    = LED_DATA_W,
  parameter int READ_LATENCY  = 1,
  parameter int ROUND_ROBIN   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CHANNELS-1:0]              data_req,
  input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data,
  output logic [NUM_CHANNELS-1:0]              data_rdy,
  output logic [ADDRESS_WIDTH-1:0]             mem_data_addr,
  output logic                                 mem_ren,
  input  logic [DATA_WIDTH-1:0]                mem_data
);

  localparam int IDX_W = CH_IDX_W(NUM_CHANNELS);
  // One stage per bram latency edge plus one for the address register, so
  // the tail lines up with mem_data being valid.
  localparam int PIPE_D = READ_LATENCY + 1;

  logic [ADDRESS_WIDTH-1:0] addr_arr [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  pending;
  logic [NUM_CHANNELS-1:0]  pending_nxt;
  logic [NUM_CHANNELS-1:0]  ret_mask;
  logic [NUM_CHANNELS-1:0]  eligible;
  logic [IDX_W-1:0]         rr_ptr;
  logic                     grant_valid;
  logic [IDX_W-1:0]         grant_idx;
  logic [PIPE_D-1:0]        pipe_valid;
  logic [IDX_W-1:0]         pipe_idx [PIPE_D];

  // ret_mask is the data_rdy pulse being produced on this edge. The channel
  // is still pending here, so it cannot be granted on its return edge; it
  // becomes eligible again on the edge that closes its data_rdy cycle.
  always_comb begin
    ret_mask = '0;
    if (pipe_valid[PIPE_D-1]) ret_mask[pipe_idx[PIPE_D-1]] = 1'b1;
  end

  assign eligible = data_req & ~pending & ~ret_mask;

  always_comb begin
    pending_nxt = pending & ~ret_mask;
    if (grant_valid) pending_nxt[grant_idx] = 1'b1;
  end

  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .ROUND_ROBIN  (ROUND_ROBIN),
    .IDX_W        (IDX_W)
  ) u_arb (
    .eligible    (eligible),
    .pointer     (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [DATA_WIDTH-1:0] slice_q;

    assign addr_arr[i] = data_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign data[i*DATA_WIDTH +: DATA_WIDTH] = slice_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        slice_q <= '0;
      end else if (ret_mask[i]) begin
        slice_q <= mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_addr <= '0;
      mem_ren       <= 1'b0;
      data_rdy      <= '0;
      pending       <= '0;
      rr_ptr        <= IDX_W'(NUM_CHANNELS - 1);
      pipe_valid    <= '0;
      for (int s = 0; s < PIPE_D; s++) pipe_idx[s] <= '0;
    end else begin
      mem_ren  <= grant_valid;
      data_rdy <= ret_mask;
      pending  <= pending_nxt;
      if (grant_valid) begin
        mem_data_addr <= addr_arr[grant_idx];
        rr_ptr        <= grant_idx;
      end
      pipe_valid  <= {pipe_valid[PIPE_D-2:0], grant_valid};
      pipe_idx[0] <= grant_idx;
      for (int s = PIPE_D - 1; s > 0; s--) pipe_idx[s] <= pipe_idx[s-1];
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: four instances cover round robin
// (RL=1), fixed priority (RL=1), round robin with RL=3 and the one-channel
// case (RL=2). Each instance has a bram model whose data is addr[7:0].
module tb_mem_read_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // instance a: N=8, RL=1, round robin
  logic [7:0]  a_req = '0;
  logic [71:0] a_addr = '0;
  logic [63:0] a_data;
  logic [7:0]  a_rdy;
  logic [8:0]  a_maddr;
  logic        a_ren;
  logic [7:0]  a_mdata;
  logic [7:0]  a_m1;
  // instance b: N=8, RL=1, fixed priority
  logic [7:0]  b_req = '0;
  logic [71:0] b_addr = '0;
  logic [63:0] b_data;
  logic [7:0]  b_rdy;
  logic [8:0]  b_maddr;
  logic        b_ren;
  logic [7:0]  b_mdata;
  logic [7:0]  b_m1;
  // instance c: N=8, RL=3, round robin
  logic [7:0]  c_req = '0;
  logic [71:0] c_addr = '0;
  logic [63:0] c_data;
  logic [7:0]  c_rdy;
  logic [8:0]  c_maddr;
  logic        c_ren;
  logic [7:0]  c_mdata;
  logic [7:0]  c_m1, c_m2, c_m3;
  // instance d: N=1, RL=2
  logic [0:0]  d_req = '0;
  logic [8:0]  d_addr = '0;
  logic [7:0]  d_data;
  logic [0:0]  d_rdy;
  logic [8:0]  d_maddr;
  logic        d_ren;
  logic [7:0]  d_mdata;
  logic [7:0]  d_m1, d_m2;

  always @(posedge clk) begin
    a_m1 <= a_maddr[7:0];
    b_m1 <= b_maddr[7:0];
    c_m1 <= c_maddr[7:0];
    c_m2 <= c_m1;
    c_m3 <= c_m2;
    d_m1 <= d_maddr[7:0];
    d_m2 <= d_m1;
  end
  assign a_mdata = a_m1;
  assign b_mdata = b_m1;
  assign c_mdata = c_m3;
  assign d_mdata = d_m2;

  mem_read_arbiter #(.NUM_CHANNELS(8), .READ_LATENCY(1), .ROUND_ROBIN(1)) dut_a (
    .clk(clk), .rst(rst), .data_req(a_req), .data_addr(a_addr), .data(a_data),
    .data_rdy(a_rdy), .mem_data_addr(a_maddr), .mem_ren(a_ren), .mem_data(a_mdata));

  mem_read_arbiter #(.NUM_CHANNELS(8), .READ_LATENCY(1), .ROUND_ROBIN(0)) dut_b (
    .clk(clk), .rst(rst), .data_req(b_req), .data_addr(b_addr), .data(b_data),
    .data_rdy(b_rdy), .mem_data_addr(b_maddr), .mem_ren(b_ren), .mem_data(b_mdata));

  mem_read_arbiter #(.NUM_CHANNELS(8), .READ_LATENCY(3), .ROUND_ROBIN(1)) dut_c (
    .clk(clk), .rst(rst), .data_req(c_req), .data_addr(c_addr), .data(c_data),
    .data_rdy(c_rdy), .mem_data_addr(c_maddr), .mem_ren(c_ren), .mem_data(c_mdata));

  mem_read_arbiter #(.NUM_CHANNELS(1), .READ_LATENCY(2), .ROUND_ROBIN(1)) dut_d (
    .clk(clk), .rst(rst), .data_req(d_req), .data_addr(d_addr), .data(d_data),
    .data_rdy(d_rdy), .mem_data_addr(d_maddr), .mem_ren(d_ren), .mem_data(d_mdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int ch;
    int order [4];
    order = '{1, 2, 3, 0};

    // reset state
    tick();
    tick();
    chk("rst_a_ren", 64'(a_ren), 64'd0);
    chk("rst_a_maddr", 64'(a_maddr), 64'd0);
    chk("rst_a_rdy", 64'(a_rdy), 64'd0);
    chk("rst_a_data", a_data, 64'd0);
    chk("rst_b_ren", 64'(b_ren), 64'd0);
    chk("rst_c_rdy", 64'(c_rdy), 64'd0);
    chk("rst_d_ren", 64'(d_ren), 64'd0);
    rst = 1'b0;

    // single request: ch3, addr 62
    a_req[3] = 1'b1;
    a_addr[3*9 +: 9] = 9'd62;
    tick();
    chk("single_ren_e0", 64'(a_ren), 64'd1);
    chk("single_maddr_e0", 64'(a_maddr), 64'd62);
    chk("single_rdy_e0", 64'(a_rdy), 64'd0);
    tick();
    chk("single_ren_e1", 64'(a_ren), 64'd0);
    chk("single_rdy_e1", 64'(a_rdy), 64'd0);
    tick();
    chk("single_rdy_e2", 64'(a_rdy), 64'h08);
    chk("single_data_e2", 64'(a_data[3*8 +: 8]), 64'd62);
    a_req = '0;
    tick();
    chk("single_rdy_e3", 64'(a_rdy), 64'd0);
    chk("single_hold_e3", 64'(a_data[3*8 +: 8]), 64'd62);
    chk("single_ren_e3", 64'(a_ren), 64'd0);

    // round robin, all 8 requesting from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_req = 8'hFF;
    for (int i = 0; i < 8; i++) a_addr[i*9 +: 9] = 9'(10 + i);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rr_ren", 64'(a_ren), 64'd1);
      chk("rr_maddr", 64'(a_maddr), 64'(10 + k % 8));
      if (k >= 2) begin
        ch = (k - 2) % 8;
        chk("rr_rdy", 64'(a_rdy), 64'(8'd1 << ch));
        chk("rr_data", 64'(a_data[ch*8 +: 8]), 64'(10 + ch));
      end else begin
        chk("rr_rdy_early", 64'(a_rdy), 64'd0);
      end
    end
    a_req = '0;
    tick();
    tick();
    tick();
    tick();

    // fixed priority: ch1 and ch5 continuously
    b_req = 8'h22;
    b_addr[1*9 +: 9] = 9'd21;
    b_addr[5*9 +: 9] = 9'd55;
    for (int k = 0; k < 9; k++) begin
      tick();
      case (k % 3)
        0: begin
          chk("fp_ren", 64'(b_ren), 64'd1);
          chk("fp_maddr", 64'(b_maddr), 64'd21);
          if (k >= 3) begin
            chk("fp_rdy5", 64'(b_rdy), 64'h20);
            chk("fp_data5", 64'(b_data[5*8 +: 8]), 64'd55);
          end else begin
            chk("fp_rdy_first", 64'(b_rdy), 64'd0);
          end
        end
        1: begin
          chk("fp_ren", 64'(b_ren), 64'd1);
          chk("fp_maddr", 64'(b_maddr), 64'd55);
          chk("fp_rdy_none", 64'(b_rdy), 64'd0);
        end
        default: begin
          chk("fp_ren_gap", 64'(b_ren), 64'd0);
          chk("fp_maddr_hold", 64'(b_maddr), 64'd55);
          chk("fp_rdy1", 64'(b_rdy), 64'h02);
          chk("fp_data1", 64'(b_data[1*8 +: 8]), 64'd21);
        end
      endcase
    end
    b_req = '0;
    tick();
    tick();
    tick();

    // latency sweep RL=3: ch0 addr 1
    c_req = 8'h01;
    c_addr[0 +: 9] = 9'd1;
    tick();
    chk("rl3_ren", 64'(c_ren), 64'd1);
    chk("rl3_maddr", 64'(c_maddr), 64'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("rl3_rdy_wait", 64'(c_rdy), 64'd0);
    end
    tick();
    chk("rl3_rdy_e4", 64'(c_rdy), 64'h01);
    chk("rl3_data_e4", 64'(c_data[0 +: 8]), 64'd1);

    // back-to-back ch0..ch3; pointer sits at 0 so ch1 leads
    c_req = 8'h0F;
    for (int i = 0; i < 4; i++) c_addr[i*9 +: 9] = 9'(100 + i);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_ren", 64'(c_ren), 64'd1);
      chk("b2b_maddr", 64'(c_maddr), 64'(100 + order[k]));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b2b_rdy", 64'(c_rdy), 64'(8'd1 << order[k]));
      chk("b2b_data", 64'(c_data[order[k]*8 +: 8]), 64'(100 + order[k]));
      c_req[order[k]] = 1'b0;
    end
    tick();
    chk("b2b_rdy_end", 64'(c_rdy), 64'd0);

    // reset mid-flight: ch2 granted, reset on the next edge
    a_req = 8'h04;
    a_addr[2*9 +: 9] = 9'd77;
    tick();
    chk("midrst_ren", 64'(a_ren), 64'd1);
    chk("midrst_maddr", 64'(a_maddr), 64'd77);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_req = '0;
    chk("postrst_ren", 64'(a_ren), 64'd0);
    chk("postrst_maddr", 64'(a_maddr), 64'd0);
    chk("postrst_rdy", 64'(a_rdy), 64'd0);
    chk("postrst_data", a_data, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("postrst_no_rdy", 64'(a_rdy), 64'd0);
    end
    a_req = 8'h05;
    a_addr[0 +: 9] = 9'd5;
    tick();
    chk("postrst_ch0_first", 64'(a_maddr), 64'd5);
    tick();
    chk("postrst_ch2_next", 64'(a_maddr), 64'd77);
    a_req = '0;
    tick();
    chk("postrst_rdy0", 64'(a_rdy), 64'h01);
    chk("postrst_data0", 64'(a_data[0 +: 8]), 64'd5);
    tick();
    chk("postrst_rdy2", 64'(a_rdy), 64'h04);
    chk("postrst_data2", 64'(a_data[2*8 +: 8]), 64'd77);
    tick();

    // request withdrawal: ch4 dropped after grant
    a_req = 8'h10;
    a_addr[4*9 +: 9] = 9'd44;
    tick();
    chk("wd_maddr", 64'(a_maddr), 64'd44);
    a_req = '0;
    tick();
    chk("wd_rdy_e1", 64'(a_rdy), 64'd0);
    tick();
    chk("wd_rdy_e2", 64'(a_rdy), 64'h10);
    chk("wd_data_e2", 64'(a_data[4*8 +: 8]), 64'd44);

    // req held through the pulse is re-granted on the edge after it
    a_req = 8'h10;
    a_addr[4*9 +: 9] = 9'd45;
    tick();
    chk("hold_ren_g", 64'(a_ren), 64'd1);
    chk("hold_maddr_g", 64'(a_maddr), 64'd45);
    tick();
    chk("hold_ren_g1", 64'(a_ren), 64'd0);
    tick();
    chk("hold_rdy_g2", 64'(a_rdy), 64'h10);
    chk("hold_ren_g2", 64'(a_ren), 64'd0);
    tick();
    chk("hold_regrant_g3", 64'(a_ren), 64'd1);
    chk("hold_rdy_g3", 64'(a_rdy), 64'd0);
    a_req = '0;
    tick();
    tick();

    // single channel, RL=2
    d_req = 1'b1;
    d_addr = 9'd7;
    tick();
    chk("n1_ren", 64'(d_ren), 64'd1);
    chk("n1_maddr", 64'(d_maddr), 64'd7);
    tick();
    chk("n1_rdy_e1", 64'(d_rdy), 64'd0);
    tick();
    chk("n1_rdy_e2", 64'(d_rdy), 64'd0);
    tick();
    chk("n1_rdy_e3", 64'(d_rdy), 64'd1);
    chk("n1_data_e3", 64'(d_data), 64'd7);
    d_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
